// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its sequencer front-end.
// Holds the opcode encodings, the legal-opcode check and the sequencer FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h4;
    localparam logic [3:0] ALU_OR  = 4'h5;
    localparam logic [3:0] ALU_XOR = 4'h6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
               (op == ALU_OR)  || (op == ALU_XOR);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU.
// flags_out = {flags_in[7:4], N, V, C, Z}; C is carry for ADD and borrow for SUB.
// Unsupported opcodes return result 0 and pass flags_in straight through.
module alu
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] op,
    input  logic [7:0] flags_in,
    output logic [7:0] result,
    output logic [7:0] flags_out
);

    logic [8:0] wide;
    logic       c;
    logic       v;

    // Result and flag computation for each opcode
    always_comb begin
        wide      = 9'd0;
        c         = 1'b0;
        v         = 1'b0;
        result    = 8'h00;
        flags_out = flags_in;
        case (op)
            ALU_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[7:0];
                c      = wide[8];
                v      = (a[7] == b[7]) && (result[7] != a[7]);
            end
            ALU_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[7:0];
                c      = wide[8];
                v      = (a[7] != b[7]) && (result[7] != a[7]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: result = 8'h00;
        endcase
        if (is_legal_op(op)) begin
            flags_out = {flags_in[7:4], result[7], v, c, (result == 8'h00)};
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequential front-end for the combinational alu: one request in, one response out.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// valid may not depend on ready, and the response is held stable until accepted.
// Optional feature macro ALU_SEQ_CHAIN_EN adds req_chain and a last-result register
// that can replace operand A.
module alu_sequencer
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
`ifdef ALU_SEQ_CHAIN_EN
    input  logic       req_chain,
`endif
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic [7:0] rsp_flags,
    output logic       rsp_err,
    output logic [7:0] flags_q,
    output logic [1:0] dbg_state
);

    seq_state_e state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] rsp_result_q, rsp_result_d;
    logic [7:0] rsp_flags_q, rsp_flags_d;
    logic       rsp_err_q, rsp_err_d;
    logic [7:0] flags_d;
    logic [7:0] alu_result;
    logic [7:0] alu_flags;
`ifdef ALU_SEQ_CHAIN_EN
    logic [7:0] last_q, last_d;
`endif

    alu u_alu (
        .a         (a_q),
        .b         (b_q),
        .op        (op_q),
        .flags_in  (flags_q),
        .result    (alu_result),
        .flags_out (alu_flags)
    );

    // Next-state, operand latching and response capture
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        flags_d      = flags_q;
`ifdef ALU_SEQ_CHAIN_EN
        last_d       = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
`ifdef ALU_SEQ_CHAIN_EN
                    if (req_chain) a_d = last_q;
`endif
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
                if (is_legal_op(op_q)) begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = alu_flags;
                    rsp_err_d    = 1'b0;
                    flags_d      = alu_flags;
`ifdef ALU_SEQ_CHAIN_EN
                    last_d       = alu_result;
`endif
                end else begin
                    // Illegal op: the ALU output is ignored and flags are left alone
                    rsp_result_d = 8'h00;
                    rsp_flags_d  = flags_q;
                    rsp_err_d    = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= 4'h0;
            a_q          <= 8'h00;
            b_q          <= 8'h00;
            rsp_result_q <= 8'h00;
            rsp_flags_q  <= 8'h00;
            rsp_err_q    <= 1'b0;
            flags_q      <= 8'h00;
`ifdef ALU_SEQ_CHAIN_EN
            last_q       <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
            flags_q      <= flags_d;
`ifdef ALU_SEQ_CHAIN_EN
            last_q       <= last_d;
`endif
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;
    assign dbg_state  = state_q;

endmodule
